// File: rtl/vga_pixel_engine.sv
// Bit-mapped VGA pixel engine: VRAM and register file on a byte-addressed bus,
// with a 1/2/4 bpp pixel fetch through a 16-entry palette and a blank-synchronised read stall.
//
// stall FSM states
//   state        | meaning
//   ST_IDLE      | no stall pending, data_ready = 1
//   ST_WAIT_LOW  | stall requested while blank = 1, waiting for blank to drop
//   ST_WAIT_RISE | waiting for the next 0 -> 1 transition of blank
module vga_pixel_engine #(
   parameter int VRAM_BITS = 512,
   parameter int IDX_W     = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  address,
   input  logic [31:0] data_in,
   input  logic [1:0]  data_write_n,
   input  logic [1:0]  data_read_n,
   output logic [31:0] data_out,
   output logic        data_ready,
   input  logic        blank,
   input  logic        new_scanline,
   input  logic        frame_start,
   output logic [5:0]  rgb
);

   localparam int                VRAM_WORDS   = VRAM_BITS / 32;
   localparam logic [7:0]        VRAM_BYTES_L = 8'(VRAM_BITS / 8);
   localparam logic [IDX_W+1:0]  MOD          = (IDX_W+2)'(VRAM_BITS);

   localparam logic [6:0] REG_STRIDE = 7'h50;
   localparam logic [6:0] REG_SIZE   = 7'h54;
   localparam logic [6:0] REG_MODE   = 7'h58;
   localparam logic [6:0] REG_START  = 7'h5C;
   localparam logic [6:0] REG_STALL  = 7'h60;
   localparam logic [6:0] REG_ROW    = 7'h64;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_LOW  = 2'd1,
      ST_WAIT_RISE = 2'd2
   } stall_state_t;

   // Operands are assumed below VRAM_BITS (a) and below 2^IDX_W (b), so two
   // conditional subtractions are enough to bring the sum back into range.
   function automatic logic [IDX_W-1:0] add_mod(input logic [IDX_W-1:0] a,
                                                input logic [IDX_W-1:0] b);
      logic [IDX_W+1:0] s;
      s = {2'b00, a} + {2'b00, b};
      if (s >= MOD) s = s - MOD;
      if (s >= MOD) s = s - MOD;
      return s[IDX_W-1:0];
   endfunction

   logic [VRAM_BITS-1:0] vram;
   logic [5:0]           palette [16];
   logic [IDX_W-1:0]     stride;
   logic [IDX_W-1:0]     start_offset;
   logic [6:0]           xsz;
   logic [6:0]           ysz;
   logic [1:0]           bpp_sel;

   logic [IDX_W-1:0]     index;
   logic [IDX_W-1:0]     row_base;
   logic [6:0]           px_x;
   logic [6:0]           px_y;
   logic [15:0]          row;

   logic                 wr_en;
   logic                 wr_32;
   logic                 rd_en;
   logic                 vram_hit;
   logic                 pal_hit;
   logic                 vram_wr;
   logic [2:0]           pal_cnt;
   logic [2:0]           bpp;
   logic [3:0]           cidx;

   stall_state_t         stall_state;
   stall_state_t         stall_next;

   assign wr_en    = (data_write_n != 2'b11);
   assign wr_32    = (data_write_n == 2'b10);
   assign rd_en    = (data_read_n != 2'b11);
   assign vram_hit = ({1'b0, address} < VRAM_BYTES_L);
   assign pal_hit  = (address[6:4] == 3'b100);
   assign vram_wr  = wr_32 && vram_hit && (address[1:0] == 2'b00);

   always_comb begin
      pal_cnt = 3'd1;
      case (data_write_n)
         2'b01:   pal_cnt = 3'd2;
         2'b10:   pal_cnt = 3'd4;
         default: pal_cnt = 3'd1;
      endcase
   end

   always_comb begin
      bpp = 3'd1;
      case (bpp_sel)
         2'd1:    bpp = 3'd2;
         2'd2:    bpp = 3'd4;
         default: bpp = 3'd1;
      endcase
   end

   // ---------------- register file ----------------
   always_ff @(posedge clk) begin
      if (vram_wr) begin
         for (int w = 0; w < VRAM_WORDS; w++) begin
            if (address[6:2] == 5'(w)) vram[w*32 +: 32] <= data_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stride       <= IDX_W'(20);
         start_offset <= '0;
         xsz          <= 7'd51;
         ysz          <= 7'd1;
         bpp_sel      <= 2'd0;
         for (int k = 0; k < 16; k++) palette[k] <= 6'd0;
         palette[0]   <= 6'b010000;
         palette[1]   <= 6'b001011;
      end else if (wr_en) begin
         // Multi-byte palette writes that run past entry 15 drop the excess bytes.
         if (pal_hit) begin
            for (int k = 0; k < 4; k++) begin
               if ((3'(k) < pal_cnt) && (({1'b0, address[3:0]} + 5'(k)) < 5'd16))
                  palette[address[3:0] + 4'(k)] <= data_in[8*k +: 6];
            end
         end
         case (address)
            REG_STRIDE: stride       <= data_in[IDX_W-1:0];
            REG_SIZE: begin
               if (wr_32) begin
                  xsz <= data_in[6:0];
                  ysz <= data_in[22:16];
               end
            end
            REG_MODE:   bpp_sel      <= data_in[1:0];
            REG_START:  start_offset <= data_in[IDX_W-1:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      data_out = 32'd0;
      if (rd_en) begin
         if (vram_hit) begin
            for (int w = 0; w < VRAM_WORDS; w++) begin
               if (address[6:2] == 5'(w)) data_out = vram[w*32 +: 32];
            end
         end else if (pal_hit) begin
            for (int k = 0; k < 4; k++) begin
               if (({1'b0, address[3:0]} + 5'(k)) < 5'd16)
                  data_out[8*k +: 6] = palette[address[3:0] + 4'(k)];
            end
         end else begin
            case (address)
               REG_STRIDE: data_out = 32'(stride);
               REG_SIZE:   data_out = {9'd0, ysz, 9'd0, xsz};
               REG_MODE:   data_out = {30'd0, bpp_sel};
               REG_START:  data_out = 32'(start_offset);
               REG_ROW:    data_out = {16'd0, row};
               default:    data_out = 32'd0;
            endcase
         end
      end
   end

   // ---------------- read stall FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) stall_state <= ST_IDLE;
      else     stall_state <= stall_next;
   end

   always_comb begin
      stall_next = stall_state;
      case (stall_state)
         ST_IDLE: begin
            if (rd_en && (address == REG_STALL))
               stall_next = blank ? ST_WAIT_LOW : ST_WAIT_RISE;
         end
         ST_WAIT_LOW:  if (!blank) stall_next = ST_WAIT_RISE;
         ST_WAIT_RISE: if (blank)  stall_next = ST_IDLE;
         default:      stall_next = ST_IDLE;
      endcase
   end

   always_comb begin
      data_ready = (stall_state == ST_IDLE);
   end

   // ---------------- pixel walker ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         index    <= '0;
         row_base <= '0;
         px_x     <= 7'd0;
         px_y     <= 7'd0;
         row      <= 16'd0;
      end else if (frame_start) begin
         index    <= start_offset;
         row_base <= start_offset;
         px_x     <= 7'd0;
         px_y     <= 7'd0;
         row      <= 16'd0;
      end else if (new_scanline) begin
         px_x <= 7'd0;
         if (px_y == ysz) begin
            px_y     <= 7'd0;
            row_base <= add_mod(row_base, stride);
            index    <= add_mod(row_base, stride);
            if (row != 16'hFFFF) row <= row + 16'd1;
         end else begin
            px_y  <= px_y + 7'd1;
            index <= row_base;
         end
      end else if (blank) begin
         px_x <= 7'd0;
      end else if (px_x == xsz) begin
         index <= add_mod(index, IDX_W'(bpp));
         px_x  <= 7'd0;
      end else begin
         px_x <= px_x + 7'd1;
      end
   end

   always_comb begin
      logic [IDX_W-1:0] pos;
      cidx = 4'd0;
      pos  = '0;
      for (int b = 0; b < 4; b++) begin
         pos = add_mod(index, IDX_W'(b));
         if (3'(b) < bpp) cidx[b] = vram[pos];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || blank) rgb <= 6'd0;
      else              rgb <= palette[cidx];
   end

endmodule

// File: doc/vga_pixel_engine.md
VGA_PIXEL_ENGINE -- requirements
Module: vga_pixel_engine

Interface
REQ-001 SHALL have parameter VRAM_BITS, default 512, meaning framebuffer size in bits; it is a multiple of 32 and at most 512.
REQ-002 SHALL have parameter IDX_W, default 9, meaning bit-index width, equal to clog2(VRAM_BITS).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port address, input, 7 bits: register/VRAM byte address.
REQ-006 SHALL have ports data_in (input, 32 bits), data_write_n (input, 2 bits: 11 none, 00 8-bit, 01 16-bit, 10 32-bit) and data_read_n (input, 2 bits, same encoding).
REQ-007 SHALL have ports data_out (output, 32 bits) and data_ready (output, 1 bit).
REQ-008 SHALL have timing inputs blank (1 bit), new_scanline (1 bit, one-cycle pulse inside blank) and frame_start (1 bit, one-cycle pulse inside blank).
REQ-009 SHALL have output rgb, 6 bits, bbggrr.

Function
REQ-010 SHALL map VRAM at 0x00..VRAM_BITS/8-1; only 32-bit writes to word-aligned addresses update vram[addr*8 +: 32]; other write widths there are ignored.
REQ-011 SHALL implement a palette of 16 x 6-bit entries at bytes 0x40-0x4F; any write width updates palette[address-0x40] from data_in[5:0], and 16-bit/32-bit writes also update the following 1/3 entries from successive bytes.
REQ-012 SHALL implement stride at 0x50 (IDX_W bits): the row-to-row advance in bits.
REQ-013 SHALL implement pixel size at 0x54 (32-bit write): xsz = data_in[6:0] and ysz = data_in[22:16], each stored as size minus 1.
REQ-014 SHALL implement mode at 0x58: bpp_sel = data_in[1:0] (0 = 1 bpp, 1 = 2 bpp, 2 = 4 bpp, 3 = treated as 1 bpp).
REQ-015 SHALL implement start offset at 0x5C (IDX_W bits): the scroll origin, latched only at frame_start.
REQ-016 SHALL, on a read of 0x60, begin a stall: data_ready goes 0 from the next cycle and returns to 1 in the cycle after the first cycle in which blank rises (0 -> 1); a request made while blank = 1 waits for the next rise.
REQ-017 SHALL, on a read of 0x64, return {16'd0, row} without stalling, where row is the count of logical pixel rows since frame_start (16 bits, saturating).
REQ-018 SHALL keep data_ready = 1 for all accesses other than 0x60; reads of unmapped addresses return 0; data_out is 0 when no read is active.
REQ-019 SHALL form color index as vram[index +: bpp] zero-extended to 4 bits, with bits wrapping modulo VRAM_BITS.
REQ-020 SHALL follow this event priority: frame_start > new_scanline > blank > active.
REQ-021 SHALL, on frame_start: set index = row_base = start_offset; px_x = px_y = 0; row = 0.
REQ-022 SHALL, on new_scanline: set px_x = 0; if px_y == ysz, set px_y = 0, row_base = row_base + stride, index = that same value, row = row + 1; otherwise px_y + 1 and index = row_base.
REQ-023 SHALL hold index and set px_x = 0 during blank (when no pulse is present).
REQ-024 SHALL, when active with px_x == xsz, set index += bpp and px_x = 0; otherwise px_x + 1.
REQ-025 SHALL perform all index/row_base sums modulo VRAM_BITS, so there is no reset-to-zero on overflow.
REQ-026 SHALL register rgb = palette[color index] one cycle after the index is presented, and 0 in the cycle after any blank cycle.
REQ-027 SHALL apply a mode change immediately; the pixel in flight uses the new bpp at its next read.

Reset
REQ-028 SHALL, while rst = 1, set rgb = 0, data_ready = 1, data_out = 0, index = row_base = 0, px_x = px_y = 0, row = 0, stride = 20, xsz = 51, ysz = 1, bpp_sel = 0, start = 0, palette[0] = 6'b010000, palette[1] = 6'b001011, all other palette entries = 0 and the stall cleared; VRAM is not reset.
REQ-029 SHALL, on reset asserted mid-stall, release data_ready to 1 in the cycle after rst is sampled high.

Verification
REQ-030 SHALL be verified so: 1 bpp, xsz = 0, vram word0 = 0x5 -> rgb sequence P1, P0, P1, P0 ... with one-cycle latency after blank falls.
REQ-031 SHALL be verified so: 4 bpp, vram[3:0] = 0xA, palette[10] = 0x3F, xsz = 3 -> rgb = 0x3F for 4 cycles, then the next nibble's color.
REQ-032 SHALL be verified so: stride = 500, VRAM_BITS = 512, ysz = 0, two scanlines -> second row_base = 500, third = 488 (modular wrap).
REQ-033 SHALL be verified so: start = 64 written mid-frame -> no effect until frame_start, then the first pixel reads bit 64.
REQ-034 SHALL be verified so: read 0x60 while blank = 1 -> data_ready stays 0 through the active period, returns to 1 one cycle after the next blank rise; with rst pulsed mid-stall -> data_ready = 1 next cycle.
REQ-035 SHALL be verified so: frame_start and new_scanline in the same cycle -> frame_start result only, row = 0.
